wb_master_if: RTL and testbench
===============================

WB_MASTER_IF -- requirements
Module: wb_master_if

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, ack-wait cycles before abort (used only with BUS_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cpu_ce_i  input  1  CPU access request.
REQ-005 SHALL have port: cpu_addr_i  input  32  request address.
REQ-006 SHALL have port: cpu_data_i  input  32  write data.
REQ-007 SHALL have port: cpu_we_i  input  1  1 = write.
REQ-008 SHALL have port: cpu_sel_i  input  4  byte lanes.
REQ-009 SHALL have port: stall_i  input  1  pipeline stalled by another source.
REQ-010 SHALL have port: flush_i  input  1  pipeline flush; discard current result.
REQ-011 SHALL have port: cpu_data_o  output  32  read data to CPU.
REQ-012 SHALL have port: stall_req_o  output  1  stall request to pipeline.
REQ-013 SHALL have port: err_o  output  1  one-cycle bus-timeout pulse.
REQ-014 SHALL have port: wishbone_addr_o  output  32  bus address.
REQ-015 SHALL have port: wishbone_data_o  output  32  bus write data.
REQ-016 SHALL have port: wishbone_we_o  output  1  bus write enable.
REQ-017 SHALL have port: wishbone_select_o  output  4  byte select; nonzero = transaction active.
REQ-018 SHALL have port: wishbone_data_i  input  32  bus read data.
REQ-019 SHALL have port: wishbone_ack_i  input  1  bus acknowledge.

Function
REQ-020 SHALL implement states IDLE, BUSY, WAIT_STALL, FLUSH_WAIT.
REQ-021 IDLE, cpu_ce_i=1, flush_i=0: SHALL register addr/data/we/sel onto wishbone_* and enter BUSY next edge; stall_req_o=1 combinationally in that cycle.
REQ-022 IDLE, cpu_ce_i=0 or flush_i=1: SHALL keep wishbone_select_o=0, wishbone_we_o=0, stall_req_o=0.
REQ-023 BUSY: SHALL hold all wishbone_* outputs stable until wishbone_ack_i=1; stall_req_o=1 while ack=0.
REQ-024 BUSY, ack=1: SHALL drive cpu_data_o=wishbone_data_i and stall_req_o=0 combinationally that cycle, capture data into read buffer, clear wishbone_select_o/we_o at edge.
REQ-025 BUSY ack exit: stall_i=1 -> WAIT_STALL; else -> IDLE.
REQ-026 WAIT_STALL: SHALL drive cpu_data_o from read buffer, stall_req_o=0, no bus activity; stall_i=0 -> IDLE.
REQ-027 BUSY, flush_i=1, ack=0: SHALL enter FLUSH_WAIT; the bus transaction SHALL NOT be aborted.
REQ-028 BUSY, flush_i=1 and ack=1 same cycle: SHALL complete, discard data, go to IDLE.
REQ-029 FLUSH_WAIT: SHALL hold wishbone_* until ack, discard data, cpu_data_o=0; stall_req_o=cpu_ce_i; ack -> IDLE.
REQ-030 cpu_data_o SHALL be 0 in IDLE and FLUSH_WAIT, and in BUSY while ack=0.
REQ-031 wishbone_ack_i SHALL be ignored in IDLE and WAIT_STALL.
REQ-032 Back-to-back: new request SHALL NOT issue in the ack cycle; minimum 1 IDLE cycle between transactions.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE, all wishbone_* outputs=0, read buffer=0, err_o=0, timeout counter=0, regardless of clk.
REQ-034 Reset mid-BUSY SHALL drop the transaction (select=0) with no ack handling after release.

Configuration
REQ-035 Macro BUS_TIMEOUT_EN defined: an 8-bit-min counter SHALL clear on BUSY entry, count each BUSY/FLUSH_WAIT cycle with ack=0; on reaching TIMEOUT_CYCLES it SHALL clear wishbone_select_o/we_o, pulse err_o 1 cycle, return cpu_data_o=0 with stall_req_o=0, and exit as per REQ-025/REQ-029.
REQ-036 Macro undefined: no counter SHALL exist, err_o SHALL be constant 0, BUSY waits indefinitely.

Verification
REQ-037 Read 0x80000010, sel=4'hF, ack after 3 cycles with data 0xDEADBEEF -> stall_req_o high 3 cycles, cpu_data_o=0xDEADBEEF in ack cycle, select=0 next edge.
REQ-038 Write 0x80000020 data 0x12345678 sel=4'h3 -> wishbone_we_o=1, addr/data/sel stable until ack, then we=0.
REQ-039 Read acked while stall_i=1 for 2 more cycles, data 0xA5A5A5A5 -> cpu_data_o=0xA5A5A5A5 held through WAIT_STALL, no new bus cycle.
REQ-040 flush_i pulse in 2nd BUSY cycle, ack 2 cycles later -> bus held until ack, cpu_data_o=0, IDLE after ack.
REQ-041 rst low mid-BUSY -> select/we/addr=0 same cycle; late ack after release ignored.
REQ-042 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> select cleared after 4 BUSY cycles, err_o=1 for exactly 1 cycle, stall_req_o=0.

Source files
------------

// File: rtl/wb_master_if.sv
// Wishbone master bridging a stalling CPU pipeline to a single-outstanding bus; BUS_TIMEOUT_EN adds an ack timeout.
// Latency: request registered onto the bus next edge; read data returned combinationally in the ack cycle.
// Backpressure: stall_req_o holds the pipeline until ack; flushed transactions still complete on the bus.
module wb_master_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] cpu_data_o,
    output logic        stall_req_o,
    output logic        err_o,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_select_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2,
        FLUSH_WAIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        tmo;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);
    // Timeout fires on the ack-less cycle that would bring the count to the limit.
    assign tmo = ((state_q == BUSY) || (state_q == FLUSH_WAIT)) && !wishbone_ack_i
                 && (cnt_inc == CW'(TIMEOUT_CYCLES));
    assign err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = we_q;
        sel_d       = sel_q;
        rbuf_d      = rbuf_q;
        cpu_data_o  = 32'h0;
        stall_req_o = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d = cnt_q;
        err_d = tmo;
        if (((state_q == BUSY) || (state_q == FLUSH_WAIT)) && !wishbone_ack_i) begin
            cnt_d = cnt_inc;
        end
`endif
        case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    addr_d      = cpu_addr_i;
                    data_d      = cpu_data_i;
                    we_d        = cpu_we_i;
                    sel_d       = cpu_sel_i;
                    stall_req_o = 1'b1;
                    state_d     = BUSY;
`ifdef BUS_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (wishbone_ack_i) begin
                    cpu_data_o = wishbone_data_i;
                    sel_d      = 4'h0;
                    we_d       = 1'b0;
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        rbuf_d  = wishbone_data_i;
                        state_d = stall_i ? WAIT_STALL : IDLE;
                    end
                end else if (tmo) begin
                    // Aborted read leaves zero in the buffer so WAIT_STALL returns 0.
                    sel_d   = 4'h0;
                    we_d    = 1'b0;
                    rbuf_d  = 32'h0;
                    state_d = (stall_i && !flush_i) ? WAIT_STALL : IDLE;
                end else begin
                    stall_req_o = 1'b1;
                    if (flush_i) begin
                        state_d = FLUSH_WAIT;
                    end
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rbuf_q;
                if (!stall_i) begin
                    state_d = IDLE;
                end
            end
            FLUSH_WAIT: begin
                stall_req_o = cpu_ce_i && !tmo;
                if (wishbone_ack_i || tmo) begin
                    sel_d   = 4'h0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            rbuf_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rbuf_q  <= rbuf_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign wishbone_addr_o   = addr_q;
    assign wishbone_data_o   = data_q;
    assign wishbone_we_o     = we_q;
    assign wishbone_select_o = sel_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Scoreboarded directed bench for wb_master_if; bus requests and ack-cycle responses are checked by a monitor.
module tb_wb_master_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i, cpu_we_i, stall_i, flush_i, wishbone_ack_i;
    logic [31:0] cpu_addr_i, cpu_data_i, wishbone_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o, wishbone_addr_o, wishbone_data_o;
    logic        stall_req_o, err_o, wishbone_we_o;
    logic [3:0]  wishbone_select_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        stall;
    } rd_exp_t;

    bus_exp_t bus_q[$];
    rd_exp_t  rd_q[$];
    logic     prev_active = 1'b0;

    always #5 clk = ~clk;

    wb_master_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_ce_i          (cpu_ce_i),
        .cpu_addr_i        (cpu_addr_i),
        .cpu_data_i        (cpu_data_i),
        .cpu_we_i          (cpu_we_i),
        .cpu_sel_i         (cpu_sel_i),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .cpu_data_o        (cpu_data_o),
        .stall_req_o       (stall_req_o),
        .err_o             (err_o),
        .wishbone_addr_o   (wishbone_addr_o),
        .wishbone_data_o   (wishbone_data_o),
        .wishbone_we_o     (wishbone_we_o),
        .wishbone_select_o (wishbone_select_o),
        .wishbone_data_i   (wishbone_data_i),
        .wishbone_ack_i    (wishbone_ack_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        bus_exp_t b;
        b.addr = a; b.data = d; b.we = w; b.sel = s;
        bus_q.push_back(b);
    endtask

    task automatic push_rd(input logic [31:0] d, input logic s);
        rd_exp_t r;
        r.data = d; r.stall = s;
        rd_q.push_back(r);
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        cpu_ce_i = 1'b1; cpu_addr_i = a; cpu_data_i = d; cpu_we_i = w; cpu_sel_i = s;
    endtask

    task automatic noreq();
        cpu_ce_i = 1'b0; cpu_addr_i = 32'h0; cpu_data_i = 32'h0; cpu_we_i = 1'b0; cpu_sel_i = 4'h0;
    endtask

    // Monitor: a new bus cycle pops a request expectation, an acked active cycle pops a response expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && wishbone_select_o !== 4'h0 && !prev_active) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected_req", {28'h0, wishbone_select_o}, 32'h0);
            end else begin
                bus_exp_t b;
                b = bus_q.pop_front();
                chk("bus_addr", wishbone_addr_o, b.addr);
                chk("bus_data", wishbone_data_o, b.data);
                chk("bus_we", {31'h0, wishbone_we_o}, {31'h0, b.we});
                chk("bus_sel", {28'h0, wishbone_select_o}, {28'h0, b.sel});
            end
        end
        if (rst === 1'b1 && wishbone_ack_i === 1'b1 && wishbone_select_o !== 4'h0) begin
            if (rd_q.size() == 0) begin
                chk("rsp_unexpected_ack", 32'h1, 32'h0);
            end else begin
                rd_exp_t r;
                r = rd_q.pop_front();
                chk("rsp_cpu_data", cpu_data_o, r.data);
                chk("rsp_stall_req", {31'h0, stall_req_o}, {31'h0, r.stall});
            end
        end
        prev_active = (wishbone_select_o !== 4'h0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; noreq(); stall_i = 1'b0; flush_i = 1'b0;
        wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0;
        #2;
        chk("rst_sel", {28'h0, wishbone_select_o}, 32'h0);
        chk("rst_we", {31'h0, wishbone_we_o}, 32'h0);
        chk("rst_addr", wishbone_addr_o, 32'h0);
        chk("rst_data", wishbone_data_o, 32'h0);
        chk("rst_stall_req", {31'h0, stall_req_o}, 32'h0);
        chk("rst_cpu_data", cpu_data_o, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        cyc(); cyc();
        rst = 1'b1;

        // Read with ack on third BUSY cycle: three stall cycles in total
        cyc();
        req(32'h8000_0010, 32'h0, 1'b0, 4'hF);
        push_bus(32'h8000_0010, 32'h0, 1'b0, 4'hF);
        @(negedge clk); chk("rd_stall_c0", {31'h0, stall_req_o}, 32'h1);
        cyc(); noreq();
        @(negedge clk); chk("rd_stall_c1", {31'h0, stall_req_o}, 32'h1);
        chk("rd_busy_data_zero", cpu_data_o, 32'h0);
        cyc();
        @(negedge clk); chk("rd_stall_c2", {31'h0, stall_req_o}, 32'h1);
        cyc(); wishbone_ack_i = 1'b1; wishbone_data_i = 32'hDEAD_BEEF;
        push_rd(32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        cyc(); wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0;
        @(negedge clk);
        chk("rd_sel_cleared", {28'h0, wishbone_select_o}, 32'h0);
        chk("rd_idle_data", cpu_data_o, 32'h0);
        chk("rd_idle_stall", {31'h0, stall_req_o}, 32'h0);

        // Write: bus fields stable until ack, then we drops
        cyc();
        req(32'h8000_0020, 32'h1234_5678, 1'b1, 4'h3);
        push_bus(32'h8000_0020, 32'h1234_5678, 1'b1, 4'h3);
        cyc(); noreq();
        repeat (2) begin
            @(negedge clk);
            chk("wr_hold_addr", wishbone_addr_o, 32'h8000_0020);
            chk("wr_hold_data", wishbone_data_o, 32'h1234_5678);
            chk("wr_hold_we", {31'h0, wishbone_we_o}, 32'h1);
            chk("wr_hold_sel", {28'h0, wishbone_select_o}, 32'h3);
            cyc();
        end
        wishbone_ack_i = 1'b1;
        push_rd(32'h0, 1'b0);
        @(negedge clk);
        cyc(); wishbone_ack_i = 1'b0;
        @(negedge clk);
        chk("wr_we_cleared", {31'h0, wishbone_we_o}, 32'h0);
        chk("wr_sel_cleared", {28'h0, wishbone_select_o}, 32'h0);

        // Read acked under stall: buffered data held, CPU request and ack ignored
        cyc();
        req(32'h8000_0030, 32'h0, 1'b0, 4'hF);
        push_bus(32'h8000_0030, 32'h0, 1'b0, 4'hF);
        cyc(); noreq();
        wishbone_ack_i = 1'b1; wishbone_data_i = 32'hA5A5_A5A5; stall_i = 1'b1;
        push_rd(32'hA5A5_A5A5, 1'b0);
        @(negedge clk);
        cyc(); wishbone_ack_i = 1'b0; wishbone_data_i = 32'hDEAD_0000;
        req(32'h8000_0070, 32'h0, 1'b0, 4'hF);
        @(negedge clk);
        chk("ws_data_1", cpu_data_o, 32'hA5A5_A5A5);
        chk("ws_stall_req", {31'h0, stall_req_o}, 32'h0);
        chk("ws_no_bus_1", {28'h0, wishbone_select_o}, 32'h0);
        cyc(); noreq(); wishbone_ack_i = 1'b1;
        @(negedge clk);
        chk("ws_data_2", cpu_data_o, 32'hA5A5_A5A5);
        chk("ws_no_bus_2", {28'h0, wishbone_select_o}, 32'h0);
        cyc(); wishbone_ack_i = 1'b0; stall_i = 1'b0;
        @(negedge clk);
        chk("ws_data_3", cpu_data_o, 32'hA5A5_A5A5);
        cyc();
        @(negedge clk);
        chk("ws_idle_data", cpu_data_o, 32'h0);
        chk("ws_idle_sel", {28'h0, wishbone_select_o}, 32'h0);

        // Flush in second BUSY cycle: bus held until ack two cycles later
        cyc();
        req(32'h8000_0040, 32'h0, 1'b0, 4'hF);
        push_bus(32'h8000_0040, 32'h0, 1'b0, 4'hF);
        cyc(); noreq();
        @(negedge clk); chk("fl_busy_stall", {31'h0, stall_req_o}, 32'h1);
        cyc(); flush_i = 1'b1;
        @(negedge clk);
        chk("fl_flush_stall", {31'h0, stall_req_o}, 32'h1);
        chk("fl_flush_data", cpu_data_o, 32'h0);
        cyc(); flush_i = 1'b0;
        @(negedge clk);
        chk("fl_wait_sel", {28'h0, wishbone_select_o}, 32'hF);
        chk("fl_wait_addr", wishbone_addr_o, 32'h8000_0040);
        chk("fl_wait_data", cpu_data_o, 32'h0);
        chk("fl_wait_stall", {31'h0, stall_req_o}, 32'h0);
        cyc(); wishbone_ack_i = 1'b1; wishbone_data_i = 32'h1111_2222;
        push_rd(32'h0, 1'b0);
        @(negedge clk);
        cyc(); wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0;
        @(negedge clk);
        chk("fl_done_sel", {28'h0, wishbone_select_o}, 32'h0);
        chk("fl_done_data", cpu_data_o, 32'h0);

        // Flush coinciding with ack: completes straight to IDLE even with stall_i high
        cyc();
        req(32'h8000_0048, 32'h0, 1'b0, 4'hF);
        push_bus(32'h8000_0048, 32'h0, 1'b0, 4'hF);
        cyc(); noreq();
        flush_i = 1'b1; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h3333_4444; stall_i = 1'b1;
        push_rd(32'h3333_4444, 1'b0);
        @(negedge clk);
        cyc(); flush_i = 1'b0; wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0;
        @(negedge clk);
        chk("fa_discard_data", cpu_data_o, 32'h0);
        chk("fa_sel", {28'h0, wishbone_select_o}, 32'h0);
        cyc(); stall_i = 1'b0;

        // Asynchronous reset mid-BUSY, then a late ack
        req(32'h8000_0050, 32'hCAFE_F00D, 1'b1, 4'hF);
        cyc(); noreq();
        chk("rb_active_addr", wishbone_addr_o, 32'h8000_0050);
        #1 rst = 1'b0;
        #1;
        chk("rb_sel", {28'h0, wishbone_select_o}, 32'h0);
        chk("rb_we", {31'h0, wishbone_we_o}, 32'h0);
        chk("rb_addr", wishbone_addr_o, 32'h0);
        chk("rb_data", wishbone_data_o, 32'h0);
        @(negedge clk); chk("rb_stall", {31'h0, stall_req_o}, 32'h0);
        cyc(); rst = 1'b1; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h7777_7777;
        @(negedge clk);
        chk("rb_late_sel", {28'h0, wishbone_select_o}, 32'h0);
        chk("rb_late_data", cpu_data_o, 32'h0);
        chk("rb_late_stall", {31'h0, stall_req_o}, 32'h0);
        cyc(); wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0;
        @(negedge clk);
        chk("rb_after_sel", {28'h0, wishbone_select_o}, 32'h0);

        // No-ack behaviour: timeout abort, or indefinite wait without the feature
        cyc();
        req(32'h8000_0060, 32'h0, 1'b0, 4'hF);
        push_bus(32'h8000_0060, 32'h0, 1'b0, 4'hF);
        cyc(); noreq();
`ifdef BUS_TIMEOUT_EN
        repeat (3) begin
            @(negedge clk);
            chk("to_sel_held", {28'h0, wishbone_select_o}, 32'hF);
            chk("to_err_low", {31'h0, err_o}, 32'h0);
            chk("to_stall_high", {31'h0, stall_req_o}, 32'h1);
            cyc();
        end
        @(negedge clk);
        chk("to_sel_c4", {28'h0, wishbone_select_o}, 32'hF);
        chk("to_err_c4", {31'h0, err_o}, 32'h0);
        cyc();
        @(negedge clk);
        chk("to_sel_cleared", {28'h0, wishbone_select_o}, 32'h0);
        chk("to_err_pulse", {31'h0, err_o}, 32'h1);
        chk("to_stall_low", {31'h0, stall_req_o}, 32'h0);
        chk("to_data_zero", cpu_data_o, 32'h0);
        cyc();
        @(negedge clk);
        chk("to_err_one_cycle", {31'h0, err_o}, 32'h0);
`else
        repeat (10) begin
            @(negedge clk);
            chk("nt_sel_held", {28'h0, wishbone_select_o}, 32'hF);
            chk("nt_err_low", {31'h0, err_o}, 32'h0);
            chk("nt_stall_high", {31'h0, stall_req_o}, 32'h1);
            cyc();
        end
        wishbone_ack_i = 1'b1; wishbone_data_i = 32'h0BAD_CAFE;
        push_rd(32'h0BAD_CAFE, 1'b0);
        @(negedge clk);
        cyc(); wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0;
        @(negedge clk);
        chk("nt_sel_cleared", {28'h0, wishbone_select_o}, 32'h0);
        chk("nt_err_low_end", {31'h0, err_o}, 32'h0);
`endif

        repeat (3) cyc();
        chk("sb_bus_drained", bus_q.size(), 32'h0);
        chk("sb_rsp_drained", rd_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
